// File: rtl/fryer_pkg.sv
// Shared definitions for the air fryer cook timer: state codes, BCD digit limits
// and the default clock rate.
package fryer_pkg;

    localparam int STATE_W      = 3;
    localparam int DIGIT_W      = 4;
    localparam int T_1S_DEFAULT = 1_000_000;

    localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9;

    typedef enum logic [STATE_W-1:0] {
        ST_OFF   = 3'd0,
        ST_SET   = 3'd1,
        ST_RUN   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Wraps 9 -> 0 and also pulls any out-of-range code back to 0.
    function automatic logic [DIGIT_W-1:0] bcd_inc(input logic [DIGIT_W-1:0] d);
        return (d >= DIGIT_MAX) ? '0 : d + 1'b1;
    endfunction

endpackage

// File: rtl/fryer_sec_tick.sv
// Sub-second counter: counts 0..T_1S-1 while enabled, holds otherwise.
// o_tick is the raw terminal-count flag; the user qualifies it with its own enable.
module fryer_sec_tick #(
    parameter int T_1S = 1_000_000,
    parameter int TW   = $clog2(T_1S)
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tick
);

    localparam logic [TW-1:0] LAST = TW'(T_1S - 1);

    logic [TW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
        end
    end

    assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/fryer_cook_timer.sv
// Cook-time setter and countdown: owns the BCD cook time and the cook state machine.
// state | meaning
// OFF   | power switch off, digits 00
// SET   | digits adjustable, waiting for start
// RUN   | heater on, counting down once per second
// PAUSE | heater off, digits and sub-second count frozen
// DONE  | buzzer for BUZZ_S seconds, then back to SET
module fryer_cook_timer
    import fryer_pkg::*;
#(
    parameter int T_1S   = T_1S_DEFAULT,
    parameter int BUZZ_S = 3,
    parameter int TW     = $clog2(T_1S)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               power_on,
    input  logic               key_start,
    input  logic               key_pause,
    input  logic               key_cancel,
    input  logic               key_inc_ones,
    input  logic               key_inc_tens,
    output logic [DIGIT_W-1:0] tens,
    output logic [DIGIT_W-1:0] ones,
    output logic [STATE_W-1:0] state,
    output logic               heating,
    output logic               buzzer,
    output logic               done_pulse
);

    localparam int BW = (BUZZ_S > 1) ? $clog2(BUZZ_S) : 1;
    localparam logic [BW-1:0] BUZZ_LAST = BW'(BUZZ_S - 1);

    state_t             r_state, w_state_nx;
    logic [DIGIT_W-1:0] r_tens, r_ones, w_tens_nx, w_ones_nx;
    logic [BW-1:0]      r_buzz, w_buzz_nx;
    logic               r_heating, r_buzzer, r_done_pulse;
    logic               w_cnt_en, w_cnt_clr, w_tick, w_any_key;

    fryer_sec_tick #(.T_1S(T_1S), .TW(TW)) u_sec_tick (
        .clk    (clk),
        .rst    (rst),
        .i_en   (w_cnt_en),
        .i_clr  (w_cnt_clr),
        .o_tick (w_tick)
    );

    assign w_any_key = key_start | key_pause | key_cancel | key_inc_ones | key_inc_tens;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_OFF;
            r_tens       <= '0;
            r_ones       <= '0;
            r_buzz       <= '0;
            r_heating    <= 1'b0;
            r_buzzer     <= 1'b0;
            r_done_pulse <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_tens       <= w_tens_nx;
            r_ones       <= w_ones_nx;
            r_buzz       <= w_buzz_nx;
            r_heating    <= (w_state_nx == ST_RUN);
            r_buzzer     <= (w_state_nx == ST_DONE);
            r_done_pulse <= (w_state_nx == ST_DONE) && (r_state != ST_DONE);
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_tens_nx  = r_tens;
        w_ones_nx  = r_ones;
        w_buzz_nx  = '0;
        w_cnt_en   = 1'b0;
        w_cnt_clr  = 1'b0;
        if (!power_on) begin
            w_state_nx = ST_OFF;
            w_tens_nx  = '0;
            w_ones_nx  = '0;
            w_cnt_clr  = 1'b1;
        end else begin
            case (r_state)
                ST_OFF: begin
                    w_state_nx = ST_SET;
                    w_tens_nx  = '0;
                    w_ones_nx  = '0;
                    w_cnt_clr  = 1'b1;
                end
                ST_SET: begin
                    w_cnt_clr = 1'b1;
                    if (key_cancel) begin
                        w_tens_nx = '0;
                        w_ones_nx = '0;
                    end else if (key_start && (r_tens != '0 || r_ones != '0)) begin
                        w_state_nx = ST_RUN;
                    end else begin
                        if (key_inc_ones) w_ones_nx = bcd_inc(r_ones);
                        if (key_inc_tens) w_tens_nx = bcd_inc(r_tens);
                    end
                end
                ST_RUN: begin
                    if (key_cancel) begin
                        w_state_nx = ST_SET;
                        w_tens_nx  = '0;
                        w_ones_nx  = '0;
                        w_cnt_clr  = 1'b1;
                    end else begin
                        // The pause cycle still counts as run time, so resume stays exact.
                        w_cnt_en = 1'b1;
                        if (w_tick) begin
                            if (r_ones == '0) begin
                                w_ones_nx = DIGIT_MAX;
                                w_tens_nx = r_tens - 1'b1;
                            end else begin
                                w_ones_nx = r_ones - 1'b1;
                            end
                        end
                        if (w_tick && r_tens == '0 && r_ones == 4'd1) begin
                            w_state_nx = ST_DONE;
                            w_cnt_clr  = 1'b1;
                        end else if (key_pause) begin
                            w_state_nx = ST_PAUSE;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (key_cancel) begin
                        w_state_nx = ST_SET;
                        w_tens_nx  = '0;
                        w_ones_nx  = '0;
                        w_cnt_clr  = 1'b1;
                    end else if (key_start) begin
                        w_state_nx = ST_RUN;
                    end
                end
                ST_DONE: begin
                    w_tens_nx = '0;
                    w_ones_nx = '0;
                    if (w_any_key) begin
                        w_state_nx = ST_SET;
                        w_cnt_clr  = 1'b1;
                    end else begin
                        w_cnt_en  = 1'b1;
                        w_buzz_nx = r_buzz;
                        if (w_tick) begin
                            if (r_buzz == BUZZ_LAST) begin
                                w_state_nx = ST_SET;
                                w_cnt_clr  = 1'b1;
                                w_buzz_nx  = '0;
                            end else begin
                                w_buzz_nx = r_buzz + 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    w_state_nx = ST_OFF;
                    w_tens_nx  = '0;
                    w_ones_nx  = '0;
                    w_cnt_clr  = 1'b1;
                end
            endcase
        end
    end

    assign tens       = r_tens;
    assign ones       = r_ones;
    assign state      = r_state;
    assign heating    = r_heating;
    assign buzzer     = r_buzzer;
    assign done_pulse = r_done_pulse;

endmodule

// File: tb/tb_fryer_cook_timer.sv
// Directed bench for fryer_cook_timer with T_1S=10, BUZZ_S=2; inputs change and
// outputs are sampled on the falling clock edge.
module tb_fryer_cook_timer;

    localparam logic [4:0] K_START  = 5'b00001;
    localparam logic [4:0] K_PAUSE  = 5'b00010;
    localparam logic [4:0] K_CANCEL = 5'b00100;
    localparam logic [4:0] K_ONES   = 5'b01000;
    localparam logic [4:0] K_TENS   = 5'b10000;

    logic       clk = 1'b0;
    logic       rst;
    logic       power_on;
    logic       key_start, key_pause, key_cancel, key_inc_ones, key_inc_tens;
    logic [3:0] tens, ones;
    logic [2:0] state;
    logic       heating, buzzer, done_pulse;

    int n_cmp = 0;
    int n_err = 0;

    fryer_cook_timer #(.T_1S(10), .BUZZ_S(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .power_on     (power_on),
        .key_start    (key_start),
        .key_pause    (key_pause),
        .key_cancel   (key_cancel),
        .key_inc_ones (key_inc_ones),
        .key_inc_tens (key_inc_tens),
        .tens         (tens),
        .ones         (ones),
        .state        (state),
        .heating      (heating),
        .buzzer       (buzzer),
        .done_pulse   (done_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives a one-cycle key pulse; returns at the next falling edge, after it took effect.
    task automatic press(input logic [4:0] m, input int times);
        for (int i = 0; i < times; i++) begin
            {key_inc_tens, key_inc_ones, key_cancel, key_pause, key_start} = m;
            @(negedge clk);
            {key_inc_tens, key_inc_ones, key_cancel, key_pause, key_start} = '0;
        end
    endtask

    task automatic check_digits(input string tag, input int t, input int o);
        check({tag, "_tens"}, int'(tens), t);
        check({tag, "_ones"}, int'(ones), o);
    endtask

    initial begin
        rst = 1'b1;
        power_on = 1'b0;
        {key_inc_tens, key_inc_ones, key_cancel, key_pause, key_start} = '0;
        wait_cyc(3);
        check("rst_state", int'(state), 0);
        check_digits("rst", 0, 0);
        check("rst_out", int'({heating, buzzer, done_pulse}), 0);

        rst = 1'b0;
        power_on = 1'b1;
        wait_cyc(1);
        check("pwr_set", int'(state), 1);
        check_digits("pwr", 0, 0);

        press(K_ONES, 7);
        press(K_TENS, 2);
        check_digits("preset27", 2, 7);

        press(K_CANCEL, 1);
        check_digits("cancel_set", 0, 0);
        press(K_ONES, 12);
        check_digits("wrap_ones", 0, 2);
        press(K_TENS, 10);
        check_digits("wrap_tens", 0, 2);

        // Countdown from 12: ticks every 10 cycles after the start edge.
        press(K_CANCEL, 1);
        press(K_ONES, 2);
        press(K_TENS, 1);
        press(K_START, 1);
        check("run_state", int'(state), 2);
        check("run_heat", int'(heating), 1);
        wait_cyc(9);
        check_digits("run_9cyc", 1, 2);
        wait_cyc(1);
        check_digits("run_10cyc", 1, 1);
        wait_cyc(20);
        check_digits("borrow", 0, 9);
        wait_cyc(89);
        check_digits("pre_done", 0, 1);
        check("pre_done_pulse", int'(done_pulse), 0);
        wait_cyc(1);
        check("done_state", int'(state), 4);
        check_digits("done", 0, 0);
        check("done_pulse1", int'(done_pulse), 1);
        check("done_buzz1", int'(buzzer), 1);
        check("done_heat", int'(heating), 0);
        wait_cyc(1);
        check("done_pulse2", int'(done_pulse), 0);
        check("done_buzz2", int'(buzzer), 1);
        wait_cyc(18);
        check("buzz_last", int'(buzzer), 1);
        check("buzz_last_state", int'(state), 4);
        wait_cyc(1);
        check("buzz_off", int'(buzzer), 0);
        check("after_done", int'(state), 1);

        // Pause at 25 cycles into a 05 countdown, resume needs the remaining 5 cycles.
        press(K_ONES, 5);
        press(K_START, 1);
        wait_cyc(24);
        press(K_PAUSE, 1);
        check("pause_state", int'(state), 3);
        check("pause_heat", int'(heating), 0);
        check_digits("pause", 0, 3);
        wait_cyc(100);
        check_digits("pause_frozen", 0, 3);
        press(K_ONES | K_TENS, 1);
        press(K_PAUSE, 1);
        check_digits("pause_inc", 0, 3);
        check("pause_still", int'(state), 3);
        press(K_START, 1);
        check("resume_state", int'(state), 2);
        wait_cyc(4);
        check_digits("resume_4", 0, 3);
        wait_cyc(1);
        check_digits("resume_5", 0, 2);
        press(K_ONES | K_TENS | K_START, 1);
        check_digits("run_inc", 0, 2);

        press(K_CANCEL, 1);
        check("cancel_state", int'(state), 1);
        check_digits("cancel_run", 0, 0);
        check("cancel_heat", int'(heating), 0);
        press(K_START, 1);
        check("zero_start", int'(state), 1);

        // One-second cook, then an increment key ends the buzzer early.
        press(K_ONES, 1);
        press(K_START, 1);
        wait_cyc(10);
        check("short_done", int'(state), 4);
        press(K_ONES, 1);
        check("early_exit", int'(state), 1);
        check_digits("early_exit", 0, 0);
        check("early_buzz", int'(buzzer), 0);

        press(K_ONES, 4);
        press(K_START, 1);
        wait_cyc(3);
        power_on = 1'b0;
        wait_cyc(1);
        check("poff_state", int'(state), 0);
        check_digits("poff", 0, 0);
        check("poff_out", int'({heating, buzzer, done_pulse}), 0);
        power_on = 1'b1;
        wait_cyc(1);
        check("pon_state", int'(state), 1);

        press(K_ONES, 3);
        press(K_START, 1);
        wait_cyc(2);
        press(K_PAUSE, 1);
        check("rst_pause_pre", int'(state), 3);
        rst = 1'b1;
        wait_cyc(1);
        check("rst_pause", int'(state), 0);
        check_digits("rst_pause", 0, 0);
        check("rst_pause_out", int'({heating, buzzer, done_pulse}), 0);
        rst = 1'b0;
        wait_cyc(1);
        check("rst_release", int'(state), 1);

        press(K_ONES | K_TENS, 1);
        check_digits("both_inc", 1, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
